npu_config_interface: RTL and testbench
=======================================

Name: npu_config_interface

Overview:
Configuration front end of the NPU. It buffers 26-bit configuration words from the host in a synchronous FIFO. On each pop it decodes a 4-bit opcode, drives the 16-bit payload on npu_config_dout, and pulses exactly one target write-enable (weight buffers 0-7, format/count registers, schedule/offset buffers) or the NPU soft reset. It sits between the host/config bus and the NPU's internal configuration storage.

Parameters:
DEPTH, 16, FIFO entry count; must be a power of two and at least 2.
ADDR_W, 4, log2(DEPTH); FIFO pointer width.

Ports:
CKL  in  1  system clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-low reset.
npu_config_interface_din  in  26  config word: [25:22] opcode, [21:16] reserved (stored, ignored), [15:0] payload.
npu_config_fifo_write_en  in  1  push din into FIFO.
npu_config_fifo_read_en  in  1  pop one entry and dispatch it.
npu_config_dout  out  16  payload of the most recently dispatched word.
npu_config_fifo_full  out  1  FIFO holds DEPTH entries.
npu_config_fifo_empty  out  1  FIFO holds 0 entries.
npu_weight0_write_en .. npu_weight7_write_en  out  1 each  weight buffer 0..7 write strobe.
npu_input_format_write_en  out  1  input format register strobe.
npu_output_format_write_en  out  1  output format register strobe.
npu_input_cnt_write_en  out  1  input count register strobe.
npu_output_cnt_write_en  out  1  output count register strobe.
npu_sched_buf_write_en  out  1  schedule buffer write strobe.
npu_offset_buf_write_en  out  1  offset buffer write strobe.
npu_rst  out  1  active-high NPU soft-reset pulse.

Behaviour:
- Reset (RST=0, async): pointers and count cleared; empty=1, full=0; npu_config_dout=0; all strobes and npu_rst=0. Asserting reset mid-operation discards all FIFO contents immediately.
- Count register range is 0..DEPTH. full = (count==DEPTH) and empty = (count==0), both decoded combinationally from registered state. Pointers wrap modulo DEPTH.
- Push: write accepted when write_en=1 and (full=0 or a pop occurs in the same cycle).
  - A write while full with no pop is dropped silently; contents are unchanged.
- Pop: occurs when read_en=1 and empty=0.
  - A read while empty is ignored: no strobe, dout holds its value.
  - No fall-through: a word written in cycle N is poppable from cycle N+1 at the earliest.
- Simultaneous push and pop: both take effect and count is unchanged. When empty, only the push takes effect.
- Dispatch latency is 1 cycle. On the edge that pops, register the popped [15:0] into npu_config_dout (held until the next pop) and the decoded strobe. The strobe is high for exactly the following cycle. Back-to-back pops give back-to-back single-cycle strobes.
- Opcode decode (one-hot, at most one output high per cycle):
  - 0: NOP; dout updates, no strobe.
  - 1-8: weight0..weight7.
  - 9: input_format.
  - 10: output_format.
  - 11: input_cnt.
  - 12: output_cnt.
  - 13: sched_buf.
  - 14: offset_buf.
  - 15: npu_rst.
- npu_rst does not clear this block's FIFO.
- Reserved bits [21:16] have no effect.

Test Plan:
- Reset: hold RST=0, then release -> empty=1, full=0, dout=0x0000, all strobes/npu_rst=0.
- Single dispatch: push 0x0C0A5A5 (opcode 3, payload 0xA5A5), pop next cycle -> one cycle later dout=0xA5A5 and npu_weight2_write_en=1 for exactly 1 cycle; empty=1 afterwards.
- Full opcode sweep: push opcodes 0..15 with payload = opcode, full=1 after 16th push; pop 16 back-to-back -> strobes in order weight0..7, input_format, output_format, input_cnt, output_cnt, sched_buf, offset_buf, npu_rst, each 1 cycle, none for opcode 0; dout tracks 0x0000..0x000F.
- Boundaries: with FIFO full, push 0x3C0FFFF with no pop -> dropped, count stays 16; on empty FIFO assert read_en -> no strobe, dout unchanged.
- Simultaneous: with FIFO full, push and pop in the same cycle -> full stays 1, popped word dispatched, new word read out last. With FIFO empty, push and pop in the same cycle -> no dispatch, empty=0 next cycle.
- Reset mid-operation: 5 entries queued, pulse RST=0 asynchronously between edges -> immediate empty=1, strobes=0, dout=0; a subsequent pop yields nothing.

Source files
------------

// File: rtl/npu_config_interface.sv
// Configuration front end of the NPU: buffers 26-bit host config words in a FIFO and,
// on each pop, drives the payload and pulses the one write strobe selected by the opcode.
module npu_config_interface #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        CKL,
    input  logic        RST,
    input  logic [25:0] npu_config_interface_din,
    input  logic        npu_config_fifo_write_en,
    input  logic        npu_config_fifo_read_en,
    output logic [15:0] npu_config_dout,
    output logic        npu_config_fifo_full,
    output logic        npu_config_fifo_empty,
    output logic        npu_weight0_write_en,
    output logic        npu_weight1_write_en,
    output logic        npu_weight2_write_en,
    output logic        npu_weight3_write_en,
    output logic        npu_weight4_write_en,
    output logic        npu_weight5_write_en,
    output logic        npu_weight6_write_en,
    output logic        npu_weight7_write_en,
    output logic        npu_input_format_write_en,
    output logic        npu_output_format_write_en,
    output logic        npu_input_cnt_write_en,
    output logic        npu_output_cnt_write_en,
    output logic        npu_sched_buf_write_en,
    output logic        npu_offset_buf_write_en,
    output logic        npu_rst
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_WEIGHT0    = 4'd1,
        OP_WEIGHT1    = 4'd2,
        OP_WEIGHT2    = 4'd3,
        OP_WEIGHT3    = 4'd4,
        OP_WEIGHT4    = 4'd5,
        OP_WEIGHT5    = 4'd6,
        OP_WEIGHT6    = 4'd7,
        OP_WEIGHT7    = 4'd8,
        OP_IN_FORMAT  = 4'd9,
        OP_OUT_FORMAT = 4'd10,
        OP_IN_CNT     = 4'd11,
        OP_OUT_CNT    = 4'd12,
        OP_SCHED_BUF  = 4'd13,
        OP_OFFSET_BUF = 4'd14,
        OP_NPU_RST    = 4'd15
    } opcode_e;

    typedef struct packed {
        logic       npu_rst;
        logic       offset_buf;
        logic       sched_buf;
        logic       output_cnt;
        logic       input_cnt;
        logic       output_format;
        logic       input_format;
        logic [7:0] weight;
    } strobe_t;

    logic [25:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              do_push;
    logic              do_pop;
    logic [25:0]       head;
    opcode_e           head_op;
    logic              head_reserved_unused;
    logic              din_reserved_unused;

    strobe_t           strobe_next;
    strobe_t           strobe_q;
    logic [15:0]       dout_q;

    assign npu_config_fifo_full  = (count == CNT_W'(DEPTH));
    assign npu_config_fifo_empty = (count == '0);

    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts it.
    assign do_pop  = npu_config_fifo_read_en && !npu_config_fifo_empty;
    assign do_push = npu_config_fifo_write_en && (!npu_config_fifo_full || do_pop);

    assign head    = mem[rd_ptr];
    assign head_op = opcode_e'(head[25:22]);

    // Reserved field travels with the word but never influences dispatch.
    assign head_reserved_unused = ^head[21:16];
    assign din_reserved_unused  = ^npu_config_interface_din[21:16];

    // NOTE: the storage array has no reset; an entry is only read after a push has written it,
    // and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge CKL) begin
        if (do_push) begin
            mem[wr_ptr] <= npu_config_interface_din;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CKL or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: every field gets a default first so the decode never infers a latch.
    always_comb begin
        strobe_next = '0;
        if (do_pop) begin
            case (head_op)
                OP_WEIGHT0:    strobe_next.weight[0]     = 1'b1;
                OP_WEIGHT1:    strobe_next.weight[1]     = 1'b1;
                OP_WEIGHT2:    strobe_next.weight[2]     = 1'b1;
                OP_WEIGHT3:    strobe_next.weight[3]     = 1'b1;
                OP_WEIGHT4:    strobe_next.weight[4]     = 1'b1;
                OP_WEIGHT5:    strobe_next.weight[5]     = 1'b1;
                OP_WEIGHT6:    strobe_next.weight[6]     = 1'b1;
                OP_WEIGHT7:    strobe_next.weight[7]     = 1'b1;
                OP_IN_FORMAT:  strobe_next.input_format  = 1'b1;
                OP_OUT_FORMAT: strobe_next.output_format = 1'b1;
                OP_IN_CNT:     strobe_next.input_cnt     = 1'b1;
                OP_OUT_CNT:    strobe_next.output_cnt    = 1'b1;
                OP_SCHED_BUF:  strobe_next.sched_buf     = 1'b1;
                OP_OFFSET_BUF: strobe_next.offset_buf    = 1'b1;
                OP_NPU_RST:    strobe_next.npu_rst       = 1'b1;
                default:       strobe_next               = '0;
            endcase
        end
    end

    // Strobes last one cycle because they reload with zero whenever no pop happens.
    always_ff @(posedge CKL or negedge RST) begin
        if (!RST) begin
            strobe_q <= '0;
            dout_q   <= '0;
        end else begin
            strobe_q <= strobe_next;
            if (do_pop) begin
                dout_q <= head[15:0];
            end
        end
    end

    assign npu_config_dout            = dout_q;
    assign npu_weight0_write_en       = strobe_q.weight[0];
    assign npu_weight1_write_en       = strobe_q.weight[1];
    assign npu_weight2_write_en       = strobe_q.weight[2];
    assign npu_weight3_write_en       = strobe_q.weight[3];
    assign npu_weight4_write_en       = strobe_q.weight[4];
    assign npu_weight5_write_en       = strobe_q.weight[5];
    assign npu_weight6_write_en       = strobe_q.weight[6];
    assign npu_weight7_write_en       = strobe_q.weight[7];
    assign npu_input_format_write_en  = strobe_q.input_format;
    assign npu_output_format_write_en = strobe_q.output_format;
    assign npu_input_cnt_write_en     = strobe_q.input_cnt;
    assign npu_output_cnt_write_en    = strobe_q.output_cnt;
    assign npu_sched_buf_write_en     = strobe_q.sched_buf;
    assign npu_offset_buf_write_en    = strobe_q.offset_buf;
    assign npu_rst                    = strobe_q.npu_rst;

endmodule

// File: tb/tb_npu_config_interface.sv
// Scoreboard bench for npu_config_interface: a queue-based reference model predicts each
// cycle's outputs, and a monitor compares them against the DUT one cycle later.
module tb_npu_config_interface;

    localparam int DEPTH = 16;

    logic        CKL = 1'b0;
    logic        RST = 1'b0;
    logic [25:0] din = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [15:0] dout;
    logic        full, empty;
    logic        w0, w1, w2, w3, w4, w5, w6, w7;
    logic        in_fmt, out_fmt, in_cnt, out_cnt, sched, offset, soft_rst;

    npu_config_interface #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .CKL                        (CKL),
        .RST                        (RST),
        .npu_config_interface_din   (din),
        .npu_config_fifo_write_en   (write_en),
        .npu_config_fifo_read_en    (read_en),
        .npu_config_dout            (dout),
        .npu_config_fifo_full       (full),
        .npu_config_fifo_empty      (empty),
        .npu_weight0_write_en       (w0),
        .npu_weight1_write_en       (w1),
        .npu_weight2_write_en       (w2),
        .npu_weight3_write_en       (w3),
        .npu_weight4_write_en       (w4),
        .npu_weight5_write_en       (w5),
        .npu_weight6_write_en       (w6),
        .npu_weight7_write_en       (w7),
        .npu_input_format_write_en  (in_fmt),
        .npu_output_format_write_en (out_fmt),
        .npu_input_cnt_write_en     (in_cnt),
        .npu_output_cnt_write_en    (out_cnt),
        .npu_sched_buf_write_en     (sched),
        .npu_offset_buf_write_en    (offset),
        .npu_rst                    (soft_rst)
    );

    always #5 CKL = ~CKL;

    // Bit i of this vector is the strobe selected by opcode i+1.
    wire [14:0] dut_strobe = {soft_rst, offset, sched, out_cnt, in_cnt, out_fmt, in_fmt,
                              w7, w6, w5, w4, w3, w2, w1, w0};

    typedef struct {
        logic [14:0] strobe;
        logic [15:0] dout;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    logic [25:0] mdl_q[$];
    logic [15:0] mdl_dout = '0;
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [14:0] strobe_for(input logic [3:0] op);
        logic [14:0] one = 15'd1;
        if (op == 4'd0) return '0;
        return one << (op - 4'd1);
    endfunction

    // Drive one cycle of inputs and predict the outputs seen after the next rising edge.
    task automatic step(input logic we, input logic re, input logic [25:0] d);
        exp_t        e;
        logic [25:0] w;
        logic        pop, push;
        @(negedge CKL);
        write_en = we;
        read_en  = re;
        din      = d;
        pop  = re && (mdl_q.size() > 0);
        push = we && ((mdl_q.size() < DEPTH) || pop);
        e.strobe = '0;
        if (pop) begin
            w = mdl_q.pop_front();
            e.strobe = strobe_for(w[25:22]);
            mdl_dout = w[15:0];
        end
        if (push) mdl_q.push_back(d);
        e.dout  = mdl_dout;
        e.empty = (mdl_q.size() == 0);
        e.full  = (mdl_q.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0);
    endtask

    function automatic logic [25:0] word(input logic [3:0] op, input logic [15:0] payload);
        return {op, 6'($urandom_range(0, 63)), payload};
    endfunction

    // Monitor: one expected record per cycle, compared just after the edge it describes.
    initial begin
        forever begin
            @(posedge CKL);
            #1;
            if (RST && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("strobes", 32'(dut_strobe), 32'(mon_e.strobe));
                check("dout", 32'(dout), 32'(mon_e.dout));
                check("empty", 32'(empty), 32'(mon_e.empty));
                check("full", 32'(full), 32'(mon_e.full));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, both while held and just after release.
        #3;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_strobes", 32'(dut_strobe), 32'd0);
        repeat (2) @(posedge CKL);
        @(negedge CKL);
        RST = 1'b1;
        #1;
        check("release_empty", 32'(empty), 32'd1);
        check("release_strobes", 32'(dut_strobe), 32'd0);

        // Single dispatch: opcode 3 -> weight2 with payload 0xA5A5.
        step(1'b1, 1'b0, 26'h0C0A5A5);
        step(1'b0, 1'b1, '0);
        idle();
        idle();

        // Opcode sweep: fill to full, then drain back-to-back.
        for (int op = 0; op < 16; op++) step(1'b1, 1'b0, word(4'(op), 16'(op)));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
        idle();

        // Full FIFO: dropped write, then simultaneous push/pop, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, word(4'($urandom_range(0, 15)), 16'($urandom)));
        step(1'b1, 1'b0, 26'h3C0FFFF);
        step(1'b1, 1'b1, word(4'd14, 16'hBEEF));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

        // Empty FIFO: read is ignored; push+pop only pushes.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, word(4'd9, 16'h1234));
        step(1'b0, 1'b1, '0);
        idle();

        // Asynchronous reset between edges with entries queued and a strobe active.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, word(4'd1 + 4'(i), 16'h5000 + 16'(i)));
        step(1'b0, 1'b1, '0);
        @(posedge CKL);
        #3;
        write_en = 1'b0;
        read_en  = 1'b0;
        RST      = 1'b0;
        #1;
        check("midreset_empty", 32'(empty), 32'd1);
        check("midreset_full", 32'(full), 32'd0);
        check("midreset_dout", 32'(dout), 32'd0);
        check("midreset_strobes", 32'(dut_strobe), 32'd0);
        check("midreset_pending", 32'(exp_q.size()), 32'd0);
        mdl_q.delete();
        mdl_dout = '0;
        @(negedge CKL);
        RST = 1'b1;
        step(1'b0, 1'b1, '0);
        idle();

        // Randomized traffic with shifting push/pop bias.
        for (int i = 0; i < 600; i++) begin
            int wbias = (i < 200) ? 70 : (i < 400) ? 40 : 55;
            int rbias = (i < 200) ? 40 : (i < 400) ? 70 : 55;
            step($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < rbias, 26'($urandom));
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, '0);
        idle();

        @(posedge CKL);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
